// File: rtl/wb_port_arbiter_pkg.sv
// Shared writeback constants: source/select encoding and datapath widths.
// The writeback mux select encoder imports the same constants.
package wb_pkg;

  localparam int NSRC = 5;
  localparam int XLEN = 32;
  localparam int SELW = 3;

  localparam logic [SELW-1:0] WB_ALU   = 3'd0;
  localparam logic [SELW-1:0] WB_LOAD  = 3'd1;
  localparam logic [SELW-1:0] WB_PC4   = 3'd2;
  localparam logic [SELW-1:0] WB_PCIMM = 3'd3;
  localparam logic [SELW-1:0] WB_IMM   = 3'd4;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback sources on one side and the registered register-file write port
// on the other. The arbiter takes the slave view.
interface wb_port_arbiter_if import wb_pkg::*; ();

  logic [NSRC-1:0]      src_valid;
  logic [5*NSRC-1:0]    src_rd;
  logic [XLEN*NSRC-1:0] src_data;
  logic [NSRC-1:0]      src_ready;
  logic                 stall;
  logic                 rf_we;
  logic [4:0]           rf_rd;
  logic [XLEN-1:0]      rf_wdata;
  logic [SELW-1:0]      rf_sel;
  logic                 starve_grant;

  modport slave (
    input  src_valid, src_rd, src_data, stall,
    output src_ready, rf_we, rf_rd, rf_wdata, rf_sel, starve_grant
  );

  modport master (
    output src_valid, src_rd, src_data, stall,
    input  src_ready, rf_we, rf_rd, rf_wdata, rf_sel, starve_grant
  );

endinterface

// File: rtl/wb_port_arbiter_prio_pick.sv
// Combinational highest-index picker: one-hot and binary index of the
// highest set request bit.
module wb_prio_pick import wb_pkg::*; (
  input  logic [NSRC-1:0] req,
  output logic [NSRC-1:0] onehot,
  output logic [SELW-1:0] idx,
  output logic            any
);

  // Later iterations overwrite earlier ones, so the highest index wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = SELW'(i);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Fixed-priority (highest index) arbiter for the shared register-file write
// port, with per-source starvation override and a registered output stage.
module wb_port_arbiter import wb_pkg::*; #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  wb_port_arbiter_if.slave   bus
);

  logic [3:0]      wcnt [NSRC];
  logic [NSRC-1:0] starved;
  logic [NSRC-1:0] norm_oh;
  logic [NSRC-1:0] starve_oh;
  logic [NSRC-1:0] grant;
  logic [SELW-1:0] norm_idx;
  logic [SELW-1:0] starve_idx;
  logic [SELW-1:0] grant_idx;
  logic            norm_any;
  logic            starve_any;
  logic            granted;
  logic [4:0]      pick_rd;
  logic [XLEN-1:0] pick_data;

  // Gate with valid so a counter still at the limit after valid drops cannot
  // produce a grant to an idle source.
  always_comb begin
    starved = '0;
    for (int i = 0; i < NSRC; i++) begin
      starved[i] = bus.src_valid[i] && (wcnt[i] == 4'(STARVE_LIMIT));
    end
  end

  wb_prio_pick u_norm_pick (
    .req    (bus.src_valid),
    .onehot (norm_oh),
    .idx    (norm_idx),
    .any    (norm_any)
  );

  wb_prio_pick u_starve_pick (
    .req    (starved),
    .onehot (starve_oh),
    .idx    (starve_idx),
    .any    (starve_any)
  );

  always_comb begin
    grant     = '0;
    grant_idx = norm_idx;
    granted   = !rst && !bus.stall && norm_any;
    if (granted) begin
      if (starve_any) begin
        grant     = starve_oh;
        grant_idx = starve_idx;
      end else begin
        grant     = norm_oh;
      end
    end
  end

  assign bus.src_ready = grant;

  always_comb begin
    pick_rd   = '0;
    pick_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (grant[i]) begin
        pick_rd   = bus.src_rd[5*i +: 5];
        pick_data = bus.src_data[XLEN*i +: XLEN];
      end
    end
  end

  // Counters keep running under stall so a starved source wins the first
  // cycle the register file frees up.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (rst || !bus.src_valid[i] || grant[i]) begin
        wcnt[i] <= '0;
      end else if (wcnt[i] != 4'(STARVE_LIMIT)) begin
        wcnt[i] <= wcnt[i] + 4'd1;
      end
    end
  end

  // Address, data and select hold across idle cycles; only the enables drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rf_we        <= 1'b0;
      bus.rf_rd        <= '0;
      bus.rf_wdata     <= '0;
      bus.rf_sel       <= WB_ALU;
      bus.starve_grant <= 1'b0;
    end else if (granted) begin
      bus.rf_we        <= (pick_rd != 5'd0);
      bus.rf_rd        <= pick_rd;
      bus.rf_wdata     <= pick_data;
      bus.rf_sel       <= grant_idx;
      bus.starve_grant <= starve_any;
    end else begin
      bus.rf_we        <= 1'b0;
      bus.starve_grant <= 1'b0;
    end
  end

endmodule
